// File: rtl/regfile_pkg.sv
// Shared constants and encodings for the register-file writeback path.
package regfile_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational 2-way round-robin arbiter; ptr names the requester that wins a tie.
module rr_arbiter_2
   import regfile_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req[0] & (~req[1] | (ptr == REQ_A));
      gnt[1] = req[1] & (~req[0] | (ptr == REQ_B));
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the 8x16 register file: init sweep after reset, then
// round-robin writeback between ALU (A) and load (B) with a registered output stage.
module regfile_wb_arbiter #(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 3,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0,
   parameter bit                R0_ZERO    = 1'b1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              Write_En,
   output logic [ADDR_W-1:0] Write_Addr,
   output logic [DATA_W-1:0] Write_Data,
   output logic              init_done,
   output logic [7:0]        stall_cnt
);

   import regfile_pkg::state_t;
   import regfile_pkg::req_id_t;
   import regfile_pkg::ST_INIT;
   import regfile_pkg::ST_RUN;
   import regfile_pkg::REQ_A;
   import regfile_pkg::REQ_B;

   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q;
   req_id_t           rr_ptr;
   logic [1:0]        gnt;
   logic              handshake;
   logic              commit;
   logic              stall;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   rr_arbiter_2 u_arb (
      .req ({b_valid, a_valid}),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

   always_ff @(posedge clk) begin
      if (!clr) state_q <= ST_INIT;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && idx_q == LAST_IDX) state_d = ST_RUN;
   end

   // Grants only reach the requesters once the sweep is over.
   always_comb begin
      a_ready   = (state_q == ST_RUN) & gnt[0];
      b_ready   = (state_q == ST_RUN) & gnt[1];
      handshake = a_ready | b_ready;
      sel_addr  = a_ready ? a_addr : b_addr;
      sel_data  = a_ready ? a_data : b_data;
      commit    = handshake & ~(R0_ZERO && sel_addr == '0);
      stall     = (state_q == ST_RUN) &
                  ((a_valid & ~a_ready) | (b_valid & ~b_ready));
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         idx_q      <= '0;
         rr_ptr     <= REQ_A;
         Write_En   <= 1'b0;
         Write_Addr <= '0;
         Write_Data <= '0;
         init_done  <= 1'b0;
         stall_cnt  <= 8'd0;
      end else if (state_q == ST_INIT) begin
         Write_En   <= 1'b1;
         Write_Addr <= idx_q;
         Write_Data <= INIT_VALUE;
         idx_q      <= idx_q + 1'b1;
         if (idx_q == LAST_IDX) init_done <= 1'b1;
      end else begin
         Write_En <= commit;
         if (handshake) begin
            Write_Addr <= sel_addr;
            Write_Data <= sel_data;
            rr_ptr     <= a_ready ? REQ_B : REQ_A;
         end
         if (stall && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
      end
   end

endmodule
